// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: legal quarter-turn encodings and the
// quadrant-stage buffer state.
package cordic_pkg;

  // Legal signed quarter-turn counts for the quadrant-correction stage.
  localparam int FLIP_0    = 0;
  localparam int FLIP_P90  = 1;
  localparam int FLIP_M90  = -1;
  localparam int FLIP_P180 = 2;
  localparam int FLIP_M180 = -2;

  // Occupancy of the two-entry elastic buffer.
  typedef enum logic [1:0] {
    QcsEmpty,
    QcsOne,
    QcsFull
  } qcs_state_t;

endpackage

// File: rtl/cordic_sat_neg.sv
// Saturating two's-complement negation: the most negative value maps to
// the most positive one instead of wrapping back onto itself.
module cordic_sat_neg #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] neg,
  output logic              sat
);

  localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

  // Only the most negative input has no representable negation.
  always_comb begin
    sat = (x == MinVal);
    neg = sat ? ~MinVal : -x;
  end

endmodule

// File: rtl/cordic_quadrant_stage.sv
// Quadrant-correction stage: rotates (cos, sin) by flip*90 degrees with
// saturating negation and buffers results in a two-entry elastic FIFO.
// Optional saturation-event counter enabled by defining QCS_SAT_COUNT_EN.
module cordic_quadrant_stage
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FLIP_W = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIP_W-1:0] flip,
  input  logic [DATA_W-1:0] cos_in,
  input  logic [DATA_W-1:0] sin_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] cos_out,
  output logic [DATA_W-1:0] sin_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              flip_err
`ifdef QCS_SAT_COUNT_EN
  ,
  output logic [15:0]       sat_cnt
`endif
);

  // Entry layout: {flip_err, tag, sin, cos}.
  localparam int unsigned EntW = 2 * DATA_W + TAG_W + 1;

  logic [DATA_W-1:0] neg_cos, neg_sin;
  logic              sat_cos, sat_sin;
  logic [DATA_W-1:0] cos_c, sin_c;
  logic              err_c, sat_c;
  int                flip_int;

  qcs_state_t        state_q, state_d;
  logic [EntW-1:0]   head_q, head_d, tail_q, tail_d, new_entry;
  logic              acc, drn;

  cordic_sat_neg #(.DATA_W(DATA_W)) u_neg_cos (
    .x   (cos_in),
    .neg (neg_cos),
    .sat (sat_cos)
  );

  cordic_sat_neg #(.DATA_W(DATA_W)) u_neg_sin (
    .x   (sin_in),
    .neg (neg_sin),
    .sat (sat_sin)
  );

  assign flip_int = int'($signed(flip));

  // Quadrant mapping; sat_c only reflects negations actually used.
  always_comb begin
    cos_c = cos_in;
    sin_c = sin_in;
    err_c = 1'b0;
    sat_c = 1'b0;
    case (flip_int)
      FLIP_0: ;
      FLIP_P90: begin
        cos_c = neg_sin;
        sin_c = cos_in;
        sat_c = sat_sin;
      end
      FLIP_M90: begin
        cos_c = sin_in;
        sin_c = neg_cos;
        sat_c = sat_cos;
      end
      FLIP_P180, FLIP_M180: begin
        cos_c = neg_cos;
        sin_c = neg_sin;
        sat_c = sat_cos | sat_sin;
      end
      default: err_c = 1'b1;
    endcase
  end

  assign new_entry = {err_c, tag_in, sin_c, cos_c};

  // Handshake flags decode the state register only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_q != QcsFull);
  assign out_valid = (state_q != QcsEmpty);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  assign {flip_err, tag_out, sin_out, cos_out} = head_q;

  // Buffer next-state: head is the output slot, tail the overflow slot.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      QcsEmpty: begin
        if (acc) begin
          head_d  = new_entry;
          state_d = QcsOne;
        end
      end
      QcsOne: begin
        if (acc && drn) begin
          head_d = new_entry;
        end else if (acc) begin
          tail_d  = new_entry;
          state_d = QcsFull;
        end else if (drn) begin
          state_d = QcsEmpty;
        end
      end
      QcsFull: begin
        if (drn) begin
          head_d  = tail_q;
          state_d = QcsOne;
        end
      end
      default: state_d = QcsEmpty;
    endcase
  end

  // Buffer state and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= QcsEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef QCS_SAT_COUNT_EN
  logic [15:0] sat_cnt_q;

  // One count per accepted sample that saturated, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (acc && sat_c && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat = sat_c;
`endif

endmodule

// File: tb/tb_cordic_quadrant_stage.sv
// Self-checking bench for cordic_quadrant_stage: directed vector table,
// backpressure and reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_cordic_quadrant_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  flip = '0;
  logic [15:0] cos_in = '0, sin_in = '0;
  logic [3:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] cos_out, sin_out;
  logic [3:0]  tag_out;
  logic        flip_err;
`ifdef QCS_SAT_COUNT_EN
  logic [15:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  cordic_quadrant_stage #(.DATA_W(16), .FLIP_W(3), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flip      (flip),
    .cos_in    (cos_in),
    .sin_in    (sin_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .tag_out   (tag_out),
    .flip_err  (flip_err)
`ifdef QCS_SAT_COUNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sat_model = 0;

  typedef struct {
    logic [15:0] c;
    logic [15:0] s;
    logic [3:0]  tag;
    bit          err;
  } exp_t;

  exp_t model_q[$];

  typedef struct {
    logic [2:0]  flip;
    logic [15:0] c;
    logic [15:0] s;
    logic [15:0] ec;
    logic [15:0] es;
    bit          eerr;
    bit          esat;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_sat(input string name);
`ifdef QCS_SAT_COUNT_EN
    check(name, 32'(sat_cnt), 32'(sat_model));
`else
    if (sat_model < 0) $display("sat model underflow in %s", name);
`endif
  endtask

  // Negation clamped to the 16-bit signed range.
  function automatic int neg_ref(input int x);
    int v;
    v = -x;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Reference rotation by f quarter turns, computed with integer arithmetic.
  task automatic ref_map(input logic [2:0] fbits, input logic [15:0] c, input logic [15:0] s,
                         output logic [15:0] co, output logic [15:0] so,
                         output bit err, output bit sat);
    int f, ci, si;
    f  = (fbits >= 3'd4) ? int'(fbits) - 8 : int'(fbits);
    ci = int'($signed(c));
    si = int'($signed(s));
    co = c;
    so = s;
    err = 1'b0;
    sat = 1'b0;
    if (f == 1) begin
      co  = 16'(neg_ref(si));
      so  = c;
      sat = (si == -32768);
    end else if (f == -1) begin
      co  = s;
      so  = 16'(neg_ref(ci));
      sat = (ci == -32768);
    end else if (f == 2 || f == -2) begin
      co  = 16'(neg_ref(ci));
      so  = 16'(neg_ref(si));
      sat = (ci == -32768) || (si == -32768);
    end else if (f != 0) begin
      err = 1'b1;
    end
  endtask

  initial begin
    vt[0] = '{3'b000, 16'h4000, 16'h1000, 16'h4000, 16'h1000, 1'b0, 1'b0};
    vt[1] = '{3'b001, 16'h2000, 16'h8000, 16'h7FFF, 16'h2000, 1'b0, 1'b1};
    vt[2] = '{3'b110, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1};
    vt[3] = '{3'b100, 16'h1234, 16'h5678, 16'h1234, 16'h5678, 1'b1, 1'b0};
    vt[4] = '{3'b111, 16'h8000, 16'h1111, 16'h1111, 16'h7FFF, 1'b0, 1'b1};
    vt[5] = '{3'b010, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0};
    vt[6] = '{3'b011, 16'hABCD, 16'h0123, 16'hABCD, 16'h0123, 1'b1, 1'b0};
    vt[7] = '{3'b001, 16'h1234, 16'h0005, 16'hFFFB, 16'h1234, 1'b0, 1'b0};
    vt[8] = '{3'b111, 16'h0003, 16'h7FFF, 16'h7FFF, 16'hFFFD, 1'b0, 1'b0};
    vt[9] = '{3'b110, 16'h8001, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0};

    // Reset state.
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_cos_out", 32'(cos_out), 0);
    check("rst_sin_out", 32'(sin_out), 0);
    check("rst_tag_out", 32'(tag_out), 0);
    check("rst_flip_err", 32'(flip_err), 0);
    check_sat("rst_sat_cnt");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single-sample vectors.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      flip      = vt[i].flip;
      cos_in    = vt[i].c;
      sin_in    = vt[i].s;
      tag_in    = 4'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (vt[i].esat) sat_model++;
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
      check($sformatf("vec%0d_cos", i), 32'(cos_out), 32'(vt[i].ec));
      check($sformatf("vec%0d_sin", i), 32'(sin_out), 32'(vt[i].es));
      check($sformatf("vec%0d_err", i), 32'(flip_err), 32'(vt[i].eerr));
      check($sformatf("vec%0d_tag", i), 32'(tag_out), i);
      check_sat($sformatf("vec%0d_sat_cnt", i));
      @(posedge clk); #1;
      check($sformatf("vec%0d_drained", i), 32'(out_valid), 0);
    end

    // Backpressure: A, B fill the buffer, C is held off.
    flip = 3'b000;
    sin_in = 16'h0000;
    out_ready = 1'b0;
    in_valid = 1'b1;
    cos_in = 16'h00A1;
    @(posedge clk); #1;
    cos_in = 16'h00B2;
    @(posedge clk); #1;
    cos_in = 16'h00C3;
    check("bp_in_ready_full", 32'(in_ready), 0);
    check("bp_head_a", 32'(cos_out), 32'h00A1);
    repeat (2) @(posedge clk);
    #1;
    check("bp_c_held_off", 32'(in_ready), 0);
    check("bp_head_still_a", 32'(cos_out), 32'h00A1);
    out_ready = 1'b1;
    check("bp_emit_a_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    check("bp_emit_b", 32'(cos_out), 32'h00B2);
    check("bp_ready_again", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_emit_c", 32'(cos_out), 32'h00C3);
    check("bp_emit_c_valid", 32'(out_valid), 1);
    @(posedge clk); #1;
    check("bp_empty_after", 32'(out_valid), 0);

    // Asynchronous reset while FULL discards everything at once.
    out_ready = 1'b0;
    in_valid = 1'b1;
    cos_in = 16'h0D0D;
    @(posedge clk); #1;
    cos_in = 16'h0E0E;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rf_full_before", 32'(in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    sat_model = 0;
    check("rf_out_valid", 32'(out_valid), 0);
    check("rf_in_ready", 32'(in_ready), 1);
    check("rf_cos_out", 32'(cos_out), 0);
    check_sat("rf_sat_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rf_no_stale%0d", i), 32'(out_valid), 0);
    end

    // Randomized traffic against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit acc, drn, err, sat;
      logic [15:0] co, so;
      exp_t e;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flip      = 3'($urandom_range(0, 7));
      cos_in    = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      sin_in    = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      tag_in    = 4'($urandom);
      @(negedge clk);
      check("rnd_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
      check("rnd_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        check("rnd_cos", 32'(cos_out), 32'(model_q[0].c));
        check("rnd_sin", 32'(sin_out), 32'(model_q[0].s));
        check("rnd_tag", 32'(tag_out), 32'(model_q[0].tag));
        check("rnd_err", 32'(flip_err), 32'(model_q[0].err));
      end
      check_sat("rnd_sat_cnt");
      acc = in_valid && (model_q.size() < 2);
      drn = out_ready && (model_q.size() > 0);
      ref_map(flip, cos_in, sin_in, co, so, err, sat);
      @(posedge clk);
      if (drn) void'(model_q.pop_front());
      if (acc) begin
        e.c = co;
        e.s = so;
        e.tag = tag_in;
        e.err = err;
        model_q.push_back(e);
        if (sat && sat_model < 65535) sat_model++;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
